// File: rtl/vram_sched_pkg.sv
// vram_sched_pkg: shared types and defaults for the VRAM write scheduler
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

package vram_sched_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_ADDR_WIDTH = `VRAM_ADDR_WIDTH;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE
    } state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/vram_write_fifo.sv
// vram_write_fifo: synchronous FIFO of pending VRAM writes with head and next-head peek
module vram_write_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [W-1:0]             head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_n;
    logic          do_push, do_pop;

    // full is sampled before any pop, so a push into a full buffer is dropped even when a pop coincides
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PW'(1)];

    // storage array needs no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap modulo DEPTH; count, full and empty update together from the same next value
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_n;
            empty <= count_n == '0;
            full  <= count_n == CW'(DEPTH);
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: buffers CPU VRAM writes and replays them only inside the writable window
module vram_write_scheduler
    import vram_sched_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_write,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_data,
    input  logic                    clr_overflow,
    input  logic                    writable,
    output logic [ADDR_WIDTH-1:0]   vram_address,
    output logic [DATA_WIDTH-1:0]   vram_data,
    output logic                    vram_write_enable,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t       state;
    logic [W-1:0] head, head_next;

    vram_write_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_write),
        .pop       (state == STROBE),
        .din       ({cpu_address, cpu_data}),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // two cycles per entry: SETUP presents address/data, STROBE commits and pops;
    // when chaining STROBE->SETUP the entry behind the head is loaded since the head pops on this edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            vram_address      <= '0;
            vram_data         <= '0;
            vram_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (writable && !empty) begin
                        state                     <= SETUP;
                        {vram_address, vram_data} <= head;
                    end
                end
                SETUP: begin
                    state             <= writable ? STROBE : IDLE;
                    vram_write_enable <= writable;
                end
                STROBE: begin
                    vram_write_enable <= 1'b0;
                    if (writable && count > CW'(1)) begin
                        state                     <= SETUP;
                        {vram_address, vram_data} <= head_next;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky drop flag; a dropped push outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) overflow <= 1'b0;
        else if (cpu_write && full) overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule
